multi_channel_hit_statistic: RTL and testbench
==============================================

Name: multi_channel_hit_statistic

Overview:
Parametrised, multi-channel successor to the single-channel hit counter. It counts hit activity on NUM_CH channels over a programmable number of tick periods, and supports level or rising-edge counting. It runs in single-shot or continuous mode, latching results into stable shadow registers. Results are read back one channel at a time through a registered mux by the slow-control/readout logic.

Parameters:
NUM_CH, 8, number of hit channels
CNT_WIDTH, 20, per-channel counter width (saturating)
WIN_WIDTH, 8, width of window-length field (tick periods per window)
SEL_WIDTH, 3, width of channel read select (must satisfy 2**SEL_WIDTH >= NUM_CH)

Ports:
clk40M  in  1  system clock
reset  in  1  reset; asynchronous, active-high
tick  in  1  one-cycle time-base strobe
hit  in  NUM_CH  raw hit levels, one per channel
start  in  1  level; rising edge arms/restarts a measurement
continuous  in  1  1 = back-to-back windows; sampled at each window end
edge_mode  in  1  0 = count cycles with hit high; 1 = count hit rising edges; latched at start
window_len  in  WIN_WIDTH  window length in ticks; latched at start; 0 treated as 1
rd_sel  in  SEL_WIDTH  channel select for readout
busy  out  1  high in ARM or COUNT
ready  out  1  result registers hold a complete window
result_stb  out  1  one-cycle pulse when result registers update
count_out  out  CNT_WIDTH  result count of channel rd_sel
sat_out  out  1  saturation flag of channel rd_sel for the latched window
win_seq  out  8  completed-window sequence number, wraps 255->0

Behaviour:
- Reset (async): state IDLE; all counters, results, flags, win_seq, count_out, sat_out, ready, result_stb, busy = 0.
- Input registration:
  - start_d <= start; start_edge = start & ~start_d.
  - hit_r <= hit; hit_rr <= hit_r.
  - Qualifier per channel: level mode = hit_r; edge mode = hit_r & ~hit_rr.
- FSM states: IDLE, ARM, COUNT, DONE.
- start_edge in any state:
  - go to ARM; clear live counters and live sat flags; tick_cnt <= 0.
  - ready <= 0; latch window_len (0 -> 1) and edge_mode.
  - win_seq is not cleared.
  - start_edge takes priority over every other event in that cycle.
- ARM: wait for tick; on tick -> COUNT. No counting occurs in ARM, including the arming tick cycle.
- COUNT, every cycle, each channel:
  - if qualifier: live <= live+1, unless live is all-ones; then it holds and the live sat flag is set.
  - On tick with tick_cnt == latched_len-1 (window end):
    - results <= live value including this cycle's increment; result sat flags likewise.
    - result_stb = 1 for one cycle; ready <= 1; win_seq <= win_seq+1.
    - continuous=1: stay in COUNT; live counters and flags <= 0 (next window starts next cycle); tick_cnt <= 0.
    - continuous=0: -> DONE.
  - Other ticks: tick_cnt <= tick_cnt+1.
- DONE: hold results; ready = 1; busy = 0; wait for start_edge.
- busy = (state == ARM or COUNT), registered with the state.
- Readout:
  - count_out and sat_out are registered one cycle after rd_sel and the result registers.
  - rd_sel >= NUM_CH -> count_out = 0, sat_out = 0.
  - Result registers change only at window end, so readout in continuous mode is stable between result_stb pulses.
- window_len, edge_mode and continuous changes mid-window:
  - window_len and edge_mode have no effect until the next start_edge.
  - continuous is sampled only at window end.
- Reset asserted mid-window: immediate return to the reset state; a partial window is never reported.

Test Plan:
- NUM_CH=4, window_len=2, level mode, single. Start; tick every 10 cycles; hit[0] held high through the window; hit[2] high 3 cycles -> ch0 = 20, ch2 = 3, ch1 = ch3 = 0; ready=1; one result_stb; win_seq=1; state DONE.
- Edge mode: hit[1] toggles 1 cycle high, 1 low, for 10 cycles inside a window -> ch1 = 5. A hit held high all window -> 1 if it rises inside the window, else 0.
- CNT_WIDTH=4, level mode, hit[3] high for 40 counted cycles -> ch3 = 15, sat_out=1 for rd_sel=3; other channels sat_out=0.
- Continuous, window_len=1, three windows with hit[0] high for 2, 5 and 0 cycles -> results 2, 5, 0 at successive result_stb pulses; win_seq 1, 2, 3. Drop continuous before the third window end -> DONE after window 3. A hit in the closing-tick cycle counts in the closing window, not the next.
- Restart and reset: start edge mid-COUNT -> ready=0, live counters cleared, ARM. Reset pulse mid-window -> all outputs 0 immediately with no clock. window_len=0 behaves as 1.
- Readout: rd_sel=7 with NUM_CH=4 -> count_out=0; changing rd_sel updates count_out exactly 1 cycle later.

Source files
------------

// File: rtl/multi_channel_hit_statistic.sv
// multi_channel_hit_statistic: counts per-channel hit activity (level or rising
// edge) over a programmable number of tick periods. Runs single-shot or
// back-to-back, latches each completed window into shadow result registers and
// exposes one channel at a time through a registered readout mux.
module multi_channel_hit_statistic #(
    parameter int NUM_CH    = 8,
    parameter int CNT_WIDTH = 20,
    parameter int WIN_WIDTH = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clk40M,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [NUM_CH-1:0]    hit,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 edge_mode,
    input  logic [WIN_WIDTH-1:0] window_len,
    input  logic [SEL_WIDTH-1:0] rd_sel,
    output logic                 busy,
    output logic                 ready,
    output logic                 result_stb,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 sat_out,
    output logic [7:0]           win_seq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic                   start_d_r;
    logic                   start_edge_s;
    logic [NUM_CH-1:0]      hit_r, hit_rr;
    logic [NUM_CH-1:0]      qual_s;
    logic                   edge_lat_r;
    logic [WIN_WIDTH-1:0]   len_lat_r;
    logic [WIN_WIDTH-1:0]   tick_cnt_r;
    logic                   win_end_s;
    logic [CNT_WIDTH-1:0]   live_cnt_r [NUM_CH];
    logic [CNT_WIDTH-1:0]   live_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]      live_sat_r;
    logic [NUM_CH-1:0]      sat_nxt_s;
    logic [CNT_WIDTH-1:0]   res_cnt_r  [NUM_CH];
    logic [NUM_CH-1:0]      res_sat_r;
    logic [CNT_WIDTH-1:0]   rd_cnt_s;
    logic                   rd_sat_s;

    assign start_edge_s = start & ~start_d_r;
    assign qual_s       = edge_lat_r ? (hit_r & ~hit_rr) : hit_r;
    // The closing tick of a window; len_lat_r is never 0, so len-1 never wraps.
    assign win_end_s    = (state_r == ST_COUNT) && tick &&
                          (tick_cnt_r == (len_lat_r - WIN_WIDTH'(1)));

    // Register start and the raw hit levels (two stages for edge detection).
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            start_d_r <= 1'b0;
            hit_r     <= '0;
            hit_rr    <= '0;
        end else begin
            start_d_r <= start;
            hit_r     <= hit;
            hit_rr    <= hit_r;
        end
    end

    // Next-state logic; a start edge restarts from ARM in any state.
    always_comb begin
        state_nxt_s = state_r;
        if (start_edge_s) begin
            state_nxt_s = ST_ARM;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_ARM:   state_nxt_s = tick ? ST_COUNT : ST_ARM;
                ST_COUNT: state_nxt_s = (win_end_s && !continuous) ? ST_DONE : ST_COUNT;
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register with busy registered alongside it.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_COUNT);
        end
    end

    // Window control: latched settings, tick counter, ready, strobe, sequence.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= '0;
            len_lat_r  <= WIN_WIDTH'(1);
            edge_lat_r <= 1'b0;
            ready      <= 1'b0;
            result_stb <= 1'b0;
            win_seq    <= 8'd0;
        end else if (start_edge_s) begin
            tick_cnt_r <= '0;
            len_lat_r  <= (window_len == '0) ? WIN_WIDTH'(1) : window_len;
            edge_lat_r <= edge_mode;
            ready      <= 1'b0;
            result_stb <= 1'b0;
        end else if (win_end_s) begin
            tick_cnt_r <= '0;
            ready      <= 1'b1;
            result_stb <= 1'b1;
            win_seq    <= win_seq + 8'd1;
        end else begin
            result_stb <= 1'b0;
            if ((state_r == ST_COUNT) && tick) begin
                tick_cnt_r <= tick_cnt_r + WIN_WIDTH'(1);
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
        end
    end

    // Saturating increment of every live counter for the current cycle.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            live_nxt_s[ch] = live_cnt_r[ch];
            sat_nxt_s[ch]  = live_sat_r[ch];
            if (qual_s[ch]) begin
                if (live_cnt_r[ch] == {CNT_WIDTH{1'b1}}) begin
                    sat_nxt_s[ch] = 1'b1;
                end else begin
                    live_nxt_s[ch] = live_cnt_r[ch] + CNT_WIDTH'(1);
                end
            end else begin
                live_nxt_s[ch] = live_cnt_r[ch];
            end
        end
    end

    // Live counters count only in COUNT; results capture them at window end.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                live_cnt_r[ch] <= '0;
                res_cnt_r[ch]  <= '0;
            end
            live_sat_r <= '0;
            res_sat_r  <= '0;
        end else if (start_edge_s) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                live_cnt_r[ch] <= '0;
            end
            live_sat_r <= '0;
        end else if (state_r == ST_COUNT) begin
            if (win_end_s) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    res_cnt_r[ch]  <= live_nxt_s[ch];
                    live_cnt_r[ch] <= continuous ? '0 : live_nxt_s[ch];
                end
                res_sat_r  <= sat_nxt_s;
                live_sat_r <= continuous ? '0 : sat_nxt_s;
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    live_cnt_r[ch] <= live_nxt_s[ch];
                end
                live_sat_r <= sat_nxt_s;
            end
        end else begin
            live_sat_r <= live_sat_r;
        end
    end

    // Readout mux; out-of-range selects read as zero.
    always_comb begin
        rd_cnt_s = '0;
        rd_sat_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_WIDTH'(i)) begin
                rd_cnt_s = res_cnt_r[i];
                rd_sat_s = res_sat_r[i];
            end else begin
                rd_sat_s = rd_sat_s;
            end
        end
    end

    // Registered readout outputs.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            count_out <= '0;
            sat_out   <= 1'b0;
        end else begin
            count_out <= rd_cnt_s;
            sat_out   <= rd_sat_s;
        end
    end

endmodule

// File: tb/tb_multi_channel_hit_statistic.sv
// Directed testbench for multi_channel_hit_statistic: two instances share the
// stimulus, one with wide counters and one with 4-bit counters for saturation.
module tb_multi_channel_hit_statistic;

    localparam int NCH = 4;

    logic        clk40M = 1'b0;
    logic        reset;
    logic        tick;
    logic [NCH-1:0] hit;
    logic        start;
    logic        continuous;
    logic        edge_mode;
    logic [7:0]  window_len;
    logic [2:0]  rd_sel;

    logic        busy, ready, result_stb, sat_out;
    logic [19:0] count_out;
    logic [7:0]  win_seq;

    logic        busy_s, ready_s, result_stb_s, sat_out_s;
    logic [3:0]  count_out_s;
    logic [7:0]  win_seq_s;

    int checks = 0;
    int errors = 0;

    always #5 clk40M = ~clk40M;

    multi_channel_hit_statistic #(
        .NUM_CH(NCH), .CNT_WIDTH(20), .WIN_WIDTH(8), .SEL_WIDTH(3)
    ) dut (
        .clk40M(clk40M), .reset(reset), .tick(tick), .hit(hit), .start(start),
        .continuous(continuous), .edge_mode(edge_mode), .window_len(window_len),
        .rd_sel(rd_sel), .busy(busy), .ready(ready), .result_stb(result_stb),
        .count_out(count_out), .sat_out(sat_out), .win_seq(win_seq)
    );

    multi_channel_hit_statistic #(
        .NUM_CH(NCH), .CNT_WIDTH(4), .WIN_WIDTH(8), .SEL_WIDTH(3)
    ) dut_s (
        .clk40M(clk40M), .reset(reset), .tick(tick), .hit(hit), .start(start),
        .continuous(continuous), .edge_mode(edge_mode), .window_len(window_len),
        .rd_sel(rd_sel), .busy(busy_s), .ready(ready_s), .result_stb(result_stb_s),
        .count_out(count_out_s), .sat_out(sat_out_s), .win_seq(win_seq_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk40M);
        #1;
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic tick_period();
        repeat (9) step();
        tick_step();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One 10-cycle continuous window on channel 0; hit sampled high on edges
    // from..to. Checks the previous window's readout after the first edge.
    task automatic cont_window(input int from, input int to, input int exp_prev);
        for (int i = 1; i <= 10; i++) begin
            hit[0] = (i >= from) && (i <= to);
            tick   = (i == 10);
            step();
            if ((i == 1) && (exp_prev >= 0)) begin
                check("cont_prev_count", 32'(count_out), 32'(exp_prev));
                check("cont_stb_one_cycle", 32'(result_stb), 32'd0);
            end
        end
        tick   = 1'b0;
        hit[0] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; hit = '0; start = 1'b0; continuous = 1'b0;
        edge_mode = 1'b0; window_len = 8'd2; rd_sel = 3'd0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_stb", 32'(result_stb), 32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_seq", 32'(win_seq), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Level mode, single shot, window_len=2: 20 counted cycles
        window_len = 8'd2; edge_mode = 1'b0; continuous = 1'b0; hit = 4'b0001;
        start_pulse();
        check("t1_busy_arm", 32'(busy), 32'd1);
        tick_step();
        repeat (2) step();
        hit[2] = 1'b1;
        repeat (3) step();
        hit[2] = 1'b0;
        repeat (4) step();
        tick_step();
        check("t1_mid_stb", 32'(result_stb), 32'd0);
        check("t1_mid_busy", 32'(busy), 32'd1);
        repeat (9) step();
        tick_step();
        check("t1_stb", 32'(result_stb), 32'd1);
        check("t1_ready", 32'(ready), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_seq", 32'(win_seq), 32'd1);
        hit = '0;
        rd_sel = 3'd0;
        step();
        check("t1_stb_pulse", 32'(result_stb), 32'd0);
        check("t1_ch0", 32'(count_out), 32'd20);
        rd_sel = 3'd2;
        check("t1_rd_latency_hold", 32'(count_out), 32'd20);
        step();
        check("t1_ch2", 32'(count_out), 32'd3);
        rd_sel = 3'd1; step();
        check("t1_ch1", 32'(count_out), 32'd0);
        rd_sel = 3'd3; step();
        check("t1_ch3", 32'(count_out), 32'd0);
        rd_sel = 3'd0; step();
        rd_sel = 3'd7; step();
        check("t1_sel7_count", 32'(count_out), 32'd0);
        check("t1_sel7_sat", 32'(sat_out), 32'd0);
        repeat (3) step();
        check("t1_done_ready", 32'(ready), 32'd1);
        check("t1_done_busy", 32'(busy), 32'd0);

        // Edge mode: toggling channel, held-high channels inside/outside window
        hit = 4'b1000; edge_mode = 1'b1; window_len = 8'd2;
        repeat (2) step();
        start_pulse();
        edge_mode = 1'b0;
        tick_step();
        for (int i = 0; i < 10; i++) begin
            hit[1] = ((i % 2) == 0);
            hit[2] = 1'b1;
            tick   = (i == 9);
            step();
        end
        tick = 1'b0; hit[1] = 1'b0;
        repeat (9) step();
        tick_step();
        check("t2_stb", 32'(result_stb), 32'd1);
        check("t2_seq", 32'(win_seq), 32'd2);
        hit = '0;
        rd_sel = 3'd1; step();
        check("t2_ch1_toggle", 32'(count_out), 32'd5);
        rd_sel = 3'd2; step();
        check("t2_ch2_rise_inside", 32'(count_out), 32'd1);
        rd_sel = 3'd3; step();
        check("t2_ch3_high_before", 32'(count_out), 32'd0);
        rd_sel = 3'd0; step();
        check("t2_ch0", 32'(count_out), 32'd0);

        // Saturation: 40 counted cycles on channel 3
        edge_mode = 1'b0; window_len = 8'd4; hit = 4'b1000;
        start_pulse();
        tick_step();
        repeat (4) tick_period();
        check("t3_stb", 32'(result_stb), 32'd1);
        check("t3_seq", 32'(win_seq), 32'd3);
        hit = '0;
        rd_sel = 3'd3; step();
        check("t3_wide_ch3", 32'(count_out), 32'd40);
        check("t3_wide_sat3", 32'(sat_out), 32'd0);
        check("t3_narrow_ch3", 32'(count_out_s), 32'd15);
        check("t3_narrow_sat3", 32'(sat_out_s), 32'd1);
        rd_sel = 3'd0; step();
        check("t3_narrow_ch0", 32'(count_out_s), 32'd0);
        check("t3_narrow_sat0", 32'(sat_out_s), 32'd0);

        // Continuous, window_len=1: three windows of 2, 5 and 0 hits
        window_len = 8'd1; continuous = 1'b1; hit = '0; rd_sel = 3'd0;
        start_pulse();
        check("t4_ready_cleared", 32'(ready), 32'd0);
        tick_step();
        cont_window(1, 2, -1);
        check("t4_w1_stb", 32'(result_stb), 32'd1);
        check("t4_w1_seq", 32'(win_seq), 32'd4);
        check("t4_w1_busy", 32'(busy), 32'd1);
        check("t4_w1_ready", 32'(ready), 32'd1);
        cont_window(5, 9, 2);
        check("t4_w2_stb", 32'(result_stb), 32'd1);
        check("t4_w2_seq", 32'(win_seq), 32'd5);
        continuous = 1'b0;
        cont_window(0, -1, 5);
        check("t4_w3_stb", 32'(result_stb), 32'd1);
        check("t4_w3_seq", 32'(win_seq), 32'd6);
        check("t4_w3_busy", 32'(busy), 32'd0);
        step();
        check("t4_w3_count", 32'(count_out), 32'd0);
        check("t4_w3_stb_low", 32'(result_stb), 32'd0);
        check("t4_w3_ready", 32'(ready), 32'd1);

        // Restart mid-COUNT with window_len=0 (acts as 1)
        window_len = 8'd0; hit = 4'b0001;
        start_pulse();
        tick_step();
        repeat (5) step();
        check("t5_busy_count", 32'(busy), 32'd1);
        start_pulse();
        check("t5_restart_ready", 32'(ready), 32'd0);
        check("t5_restart_busy", 32'(busy), 32'd1);
        tick_step();
        tick_period();
        check("t5_len0_stb", 32'(result_stb), 32'd1);
        check("t5_seq", 32'(win_seq), 32'd7);
        hit = '0;
        step();
        check("t5_restart_ch0", 32'(count_out), 32'd10);

        // Reset pulse mid-window, between clock edges
        hit = 4'b0001; window_len = 8'd1;
        start_pulse();
        tick_step();
        repeat (3) step();
        check("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #2;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_count", 32'(count_out), 32'd0);
        check("t6_rst_seq", 32'(win_seq), 32'd0);
        check("t6_rst_ready", 32'(ready), 32'd0);
        check("t6_rst_stb", 32'(result_stb), 32'd0);
        step();
        reset = 1'b0;
        tick_period();
        tick_period();
        check("t6_after_busy", 32'(busy), 32'd0);
        check("t6_after_ready", 32'(ready), 32'd0);
        check("t6_after_stb", 32'(result_stb), 32'd0);
        check("t6_after_count", 32'(count_out), 32'd0);
        hit = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
